// File: rtl/lsu_pkg.sv
// Shared codes, state encoding and access-size helper for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] WE_NONE = 2'd0;
  localparam logic [1:0] WE_BYTE = 2'd1;
  localparam logic [1:0] WE_HALF = 2'd2;
  localparam logic [1:0] WE_WORD = 2'd3;

  localparam logic [2:0] RE_NONE = 3'd0;
  localparam logic [2:0] RE_LB   = 3'd1;
  localparam logic [2:0] RE_LH   = 3'd2;
  localparam logic [2:0] RE_LW   = 3'd3;
  localparam logic [2:0] RE_LBU  = 3'd4;
  localparam logic [2:0] RE_LHU  = 3'd5;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;

  function automatic logic [2:0] size_from_funct3(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Decodes memory access codes and flags misalignment / range / funct3 faults for one request.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic [ADDR_W-1:0] i_ea,
  input  logic [2:0]        i_funct3,
  input  logic              i_is_store,
  output logic [1:0]        o_we_code,
  output logic [2:0]        o_re_code,
  output logic              o_misaligned,
  output logic              o_fault
);

  logic [2:0]      w_size;
  logic [ADDR_W:0] w_last;
  logic            w_illegal;
  logic            w_range_bad;

  always_comb begin
    w_size       = size_from_funct3(i_funct3);
    // One extra bit so an access running past 2^32 still reads as out of range.
    w_last       = {1'b0, i_ea} + (ADDR_W+1)'(w_size) - (ADDR_W+1)'(1);
    w_range_bad  = (w_last >= (ADDR_W+1)'(MEM_BYTES));
    w_illegal    = i_is_store ? (i_funct3 > F3_W)
                              : ((i_funct3 == 3'd3) || (i_funct3[2:1] == 2'b11));
    o_misaligned = ((w_size == 3'd2) && i_ea[0]) ||
                   ((w_size == 3'd4) && (i_ea[1:0] != 2'b00));
    o_fault      = w_range_bad || w_illegal;

    o_we_code = WE_NONE;
    o_re_code = RE_NONE;
    if (!w_illegal) begin
      if (i_is_store) begin
        case (i_funct3)
          F3_B:    o_we_code = WE_BYTE;
          F3_H:    o_we_code = WE_HALF;
          default: o_we_code = WE_WORD;
        endcase
      end else begin
        case (i_funct3)
          F3_B:    o_re_code = RE_LB;
          F3_H:    o_re_code = RE_LH;
          F3_W:    o_re_code = RE_LW;
          F3_BU:   o_re_code = RE_LBU;
          default: o_re_code = RE_LHU;
        endcase
      end
    end
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit: accepts one request, runs a single memory access cycle, returns a response.
// state  | meaning
// IDLE   | ready for a request; checks run on the incoming effective address
// ACCESS | one cycle driving the memory; load data captured at its closing edge
// RESP   | response held until the consumer accepts it
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [ADDR_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] mem_address,
  output logic [ADDR_W-1:0] mem_data_in,
  output logic [1:0]        mem_we,
  output logic [2:0]        mem_re,
  input  logic [ADDR_W-1:0] mem_data_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_misaligned,
  output logic              resp_fault
);

  lsu_state_e        r_state, w_next;
  logic [ADDR_W-1:0] w_ea;
  logic [1:0]        w_we;
  logic [2:0]        w_re;
  logic              w_mis, w_fault, w_accept;

  logic [ADDR_W-1:0] r_ea, r_wdata, r_resp_data;
  logic [4:0]        r_resp_rd;
  logic [1:0]        r_we;
  logic [2:0]        r_re;
  logic              r_is_store, r_mis, r_fault;

  assign w_ea     = req_base + req_offset;
  assign w_accept = (r_state == IDLE) && req_valid;

  lsu_addr_check #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_check (
    .i_ea         (w_ea),
    .i_funct3     (req_funct3),
    .i_is_store   (req_is_store),
    .o_we_code    (w_we),
    .o_re_code    (w_re),
    .o_misaligned (w_mis),
    .o_fault      (w_fault)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_we      = WE_NONE;
    mem_re      = RE_NONE;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (w_mis || w_fault) ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_address = r_ea;
        mem_data_in = r_wdata;
        mem_we      = r_we;
        mem_re      = r_re;
        w_next      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ea        <= '0;
      r_wdata     <= '0;
      r_we        <= WE_NONE;
      r_re        <= RE_NONE;
      r_is_store  <= 1'b0;
      r_mis       <= 1'b0;
      r_fault     <= 1'b0;
      r_resp_data <= '0;
      r_resp_rd   <= '0;
    end else if (w_accept) begin
      r_ea        <= w_ea;
      r_wdata     <= req_wdata;
      r_we        <= w_we;
      r_re        <= w_re;
      r_is_store  <= req_is_store;
      r_mis       <= w_mis;
      r_fault     <= w_fault;
      r_resp_data <= '0;
      r_resp_rd   <= req_is_store ? 5'd0 : req_rd;
    end else if (r_state == ACCESS) begin
      r_resp_data <= r_is_store ? '0 : mem_data_out;
    end else if ((r_state == RESP) && resp_ready) begin
      r_mis       <= 1'b0;
      r_fault     <= 1'b0;
      r_resp_data <= '0;
      r_resp_rd   <= '0;
    end
  end

  assign resp_data       = r_resp_data;
  assign resp_rd         = r_resp_rd;
  assign resp_misaligned = r_mis;
  assign resp_fault      = r_fault;

endmodule
